// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: owns the single RegFile write port and shares it among
// three writers. Immediate load always targets r0. Load and ALU writebacks
// carry their own address. Selection uses fixed priority Imm > Ld > Alu.
// An Alu or Ld request that has been denied MAX_WAIT cycles in a row is
// promoted above everything else, so no writer starves.
// Grants are combinational. The write reaches the RegFile one cycle later,
// through registered RegWriteEn/WrAddr/WrData.
// Optional feature: define RF_BYPASS_EN to expose the in-flight write on
// BypassHit/BypassData for a same-cycle reader at RdAddr.
module regfile_wr_arbiter #(
    parameter int W        = 8,
    parameter int D        = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Hold,
    input  logic         ImmReq,
    input  logic [W-1:0] ImmData,
    output logic         ImmGnt,
    input  logic         LdReq,
    input  logic [D-1:0] LdAddr,
    input  logic [W-1:0] LdData,
    output logic         LdGnt,
    input  logic         AluReq,
    input  logic [D-1:0] AluAddr,
    input  logic [W-1:0] AluData,
    output logic         AluGnt,
    output logic         RegWriteEn,
    output logic [D-1:0] WrAddr,
    output logic [W-1:0] WrData,
    input  logic [D-1:0] RdAddr,
    output logic         BypassHit,
    output logic [W-1:0] BypassData
);

    localparam logic [2:0] WAIT_MAX = 3'(MAX_WAIT);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_IMM,
        SRC_LD,
        SRC_ALU
    } src_e;

    src_e         sel;
    logic [2:0]   ld_wait_q, ld_wait_d;
    logic [2:0]   alu_wait_q, alu_wait_d;
    logic         we_q, we_d;
    logic [D-1:0] addr_q, addr_d;
    logic [W-1:0] data_q, data_d;

    // Pick at most one requester: aged Alu, then aged Ld, then Imm > Ld > Alu.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
        sel = SRC_NONE;
        if (Reset_n && !Hold) begin
            if (AluReq && alu_wait_q == WAIT_MAX)     sel = SRC_ALU;
            else if (LdReq && ld_wait_q == WAIT_MAX)  sel = SRC_LD;
            else if (ImmReq)                          sel = SRC_IMM;
            else if (LdReq)                           sel = SRC_LD;
            else if (AluReq)                          sel = SRC_ALU;
        end
    end

    assign ImmGnt = (sel == SRC_IMM);
    assign LdGnt  = (sel == SRC_LD);
    assign AluGnt = (sel == SRC_ALU);

    // Next write-port contents and aging counters for the coming edge.
    always_comb begin
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        ld_wait_d  = ld_wait_q;
        alu_wait_d = alu_wait_q;

        case (sel)
            SRC_IMM: begin
                we_d   = 1'b1;
                addr_d = '0;
                data_d = ImmData;
            end
            SRC_LD: begin
                we_d   = 1'b1;
                addr_d = LdAddr;
                data_d = LdData;
            end
            SRC_ALU: begin
                we_d   = 1'b1;
                addr_d = AluAddr;
                data_d = AluData;
            end
            default: ;
        endcase

        // Counters freeze under Hold. Otherwise they clear on grant or on an
        // idle request line, and count denied cycles up to saturation.
        if (!Hold) begin
            if (!LdReq || sel == SRC_LD)    ld_wait_d = '0;
            else if (ld_wait_q < WAIT_MAX)  ld_wait_d = ld_wait_q + 3'd1;

            if (!AluReq || sel == SRC_ALU)  alu_wait_d = '0;
            else if (alu_wait_q < WAIT_MAX) alu_wait_d = alu_wait_q + 3'd1;
        end
    end

    // Write-port and counter registers; reset drops any write in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            ld_wait_q  <= '0;
            alu_wait_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ld_wait_q  <= ld_wait_d;
            alu_wait_q <= alu_wait_d;
        end
    end

    assign RegWriteEn = we_q;
    assign WrAddr     = addr_q;
    assign WrData     = data_q;

`ifdef RF_BYPASS_EN
    assign BypassHit  = we_q && (addr_q == RdAddr);
    assign BypassData = BypassHit ? data_q : '0;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^RdAddr;
    assign BypassHit      = 1'b0;
    assign BypassData     = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter.
// A rule-level model runs alongside the DUT and is compared every negedge.
// Directed sequences carry literal expectations, followed by a randomized phase.
module tb_regfile_wr_arbiter;

    localparam int W        = 8;
    localparam int D        = 4;
    localparam int MAX_WAIT = 3;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic         Hold;
    logic         ImmReq;
    logic [W-1:0] ImmData;
    logic         ImmGnt;
    logic         LdReq;
    logic [D-1:0] LdAddr;
    logic [W-1:0] LdData;
    logic         LdGnt;
    logic         AluReq;
    logic [D-1:0] AluAddr;
    logic [W-1:0] AluData;
    logic         AluGnt;
    logic         RegWriteEn;
    logic [D-1:0] WrAddr;
    logic [W-1:0] WrData;
    logic [D-1:0] RdAddr;
    logic         BypassHit;
    logic [W-1:0] BypassData;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wr_arbiter #(.W(W), .D(D), .MAX_WAIT(MAX_WAIT)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Hold(Hold),
        .ImmReq(ImmReq), .ImmData(ImmData), .ImmGnt(ImmGnt),
        .LdReq(LdReq), .LdAddr(LdAddr), .LdData(LdData), .LdGnt(LdGnt),
        .AluReq(AluReq), .AluAddr(AluAddr), .AluData(AluData), .AluGnt(AluGnt),
        .RegWriteEn(RegWriteEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdAddr(RdAddr), .BypassHit(BypassHit), .BypassData(BypassData)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Write port as seen after the last edge, plus denied-cycle counts.
    logic         m_we;
    logic [D-1:0] m_addr;
    logic [W-1:0] m_data;
    int           m_ld_wait, m_alu_wait;

    always @(negedge Clk) begin
        int win; // 0 none, 1 imm, 2 ld, 3 alu
        if (!Reset_n) begin
            check("rst_we", RegWriteEn, 0);
            check("rst_addr", WrAddr, 0);
            check("rst_data", WrData, 0);
            check("rst_gnt", {ImmGnt, LdGnt, AluGnt}, 0);
            m_we = 0; m_addr = '0; m_data = '0;
            m_ld_wait = 0; m_alu_wait = 0;
        end else begin
            check("mdl_we", RegWriteEn, m_we);
            check("mdl_addr", WrAddr, m_addr);
            check("mdl_data", WrData, m_data);
`ifdef RF_BYPASS_EN
            check("mdl_bhit", BypassHit, (m_we && m_addr == RdAddr));
            check("mdl_bdata", BypassData, (m_we && m_addr == RdAddr) ? m_data : 0);
`else
            check("mdl_bhit", BypassHit, 0);
            check("mdl_bdata", BypassData, 0);
`endif
            win = 0;
            if (!Hold) begin
                if (AluReq && m_alu_wait == MAX_WAIT)     win = 3;
                else if (LdReq && m_ld_wait == MAX_WAIT)  win = 2;
                else if (ImmReq)                          win = 1;
                else if (LdReq)                           win = 2;
                else if (AluReq)                          win = 3;
            end
            check("mdl_gnt", {ImmGnt, LdGnt, AluGnt}, {win == 1, win == 2, win == 3});

            m_we = (win != 0);
            if (win == 1) begin m_addr = '0;      m_data = ImmData; end
            if (win == 2) begin m_addr = LdAddr;  m_data = LdData;  end
            if (win == 3) begin m_addr = AluAddr; m_data = AluData; end
            if (!Hold) begin
                m_ld_wait  = (LdReq && win != 2)  ? ((m_ld_wait  + 1 > MAX_WAIT) ? MAX_WAIT : m_ld_wait  + 1) : 0;
                m_alu_wait = (AluReq && win != 3) ? ((m_alu_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_alu_wait + 1) : 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic step_req(input logic req, input logic gnt, output logic req_o, output logic fresh);
        fresh = 1'b0;
        req_o = req;
        if (req && gnt) begin
            req_o = 1'($urandom_range(0, 1));
            fresh = req_o;
        end else if (req) begin
            if ($urandom_range(0, 15) == 0) req_o = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
            req_o = 1'b1;
            fresh = 1'b1;
        end
    endtask

    initial begin
        logic g_imm, g_ld, g_alu, fresh;

        Reset_n = 1'b0; Hold = 1'b0;
        ImmReq = 1'b1; ImmData = 8'h00;
        LdReq = 1'b1; LdAddr = '0; LdData = '0;
        AluReq = 1'b0; AluAddr = '0; AluData = '0;
        RdAddr = '0;

        // Reset holds grants low even with requests pending.
        @(negedge Clk);
        check("reset_gnt", {ImmGnt, LdGnt, AluGnt}, 0);
        check("reset_we", RegWriteEn, 0);
        next_cycle();
        Reset_n = 1'b1; ImmReq = 1'b0; LdReq = 1'b0;
        next_cycle();

        // Single load grant: same-cycle Gnt, write one cycle later.
        LdReq = 1'b1; LdAddr = 4'd5; LdData = 8'hA5;
        @(negedge Clk);
        check("single_ldgnt", {ImmGnt, LdGnt, AluGnt}, 3'b010);
        next_cycle();
        LdReq = 1'b0;
        @(negedge Clk);
        check("single_we", RegWriteEn, 1);
        check("single_addr", WrAddr, 5);
        check("single_data", WrData, 8'hA5);
        next_cycle();

        // Priority: Imm, then Ld, then Alu, one write per cycle.
        ImmReq = 1'b1; ImmData = 8'h3C;
        LdReq = 1'b1; LdAddr = 4'd2; LdData = 8'h55;
        AluReq = 1'b1; AluAddr = 4'd9; AluData = 8'h99;
        @(negedge Clk);
        check("prio_c0_gnt", {ImmGnt, LdGnt, AluGnt}, 3'b100);
        next_cycle();
        ImmReq = 1'b0;
        @(negedge Clk);
        check("prio_c1_addr", WrAddr, 0);
        check("prio_c1_data", WrData, 8'h3C);
        check("prio_c1_gnt", {ImmGnt, LdGnt, AluGnt}, 3'b010);
        next_cycle();
        LdReq = 1'b0;
        @(negedge Clk);
        check("prio_c2_wr", {WrAddr, WrData}, {4'd2, 8'h55});
        check("prio_c2_gnt", {ImmGnt, LdGnt, AluGnt}, 3'b001);
        next_cycle();
        AluReq = 1'b0;
        @(negedge Clk);
        check("prio_c3_wr", {RegWriteEn, WrAddr, WrData}, {1'b1, 4'd9, 8'h99});
        next_cycle();
        @(negedge Clk);
        check("idle_we_low", RegWriteEn, 0);
        check("idle_hold_addr", WrAddr, 9);
        next_cycle();

        // Aging: Alu denied three times by Imm, promoted on the fourth cycle.
        ImmReq = 1'b1; ImmData = 8'h01;
        LdReq = 1'b1; LdAddr = 4'd3; LdData = 8'h33;
        AluReq = 1'b1; AluAddr = 4'd4; AluData = 8'h44;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("aging_denied", {ImmGnt, LdGnt, AluGnt}, 3'b100);
            next_cycle();
        end
        @(negedge Clk);
        check("aging_alu_promoted", {ImmGnt, LdGnt, AluGnt}, 3'b001);
        next_cycle();
        AluReq = 1'b0;
        @(negedge Clk);
        check("aging_alu_written", {WrAddr, WrData}, {4'd4, 8'h44});
        check("aging_ld_promoted", {ImmGnt, LdGnt, AluGnt}, 3'b010);
        next_cycle();
        LdReq = 1'b0;
        @(negedge Clk);
        check("aging_imm_back", {ImmGnt, LdGnt, AluGnt}, 3'b100);
        next_cycle();
        ImmReq = 1'b0;

        // Hold freezes the Alu counter at 2, so Imm still wins on release.
        ImmReq = 1'b1; ImmData = 8'h77;
        AluReq = 1'b1; AluAddr = 4'd6; AluData = 8'h66;
        repeat (2) begin
            @(negedge Clk);
            check("hold_pre_gnt", {ImmGnt, LdGnt, AluGnt}, 3'b100);
            next_cycle();
        end
        Hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check("hold_no_gnt", {ImmGnt, LdGnt, AluGnt}, 3'b000);
            check("hold_we", RegWriteEn, (k == 0));
            next_cycle();
        end
        Hold = 1'b0;
        @(negedge Clk);
        check("hold_release_imm", {ImmGnt, LdGnt, AluGnt}, 3'b100);
        check("hold_release_we", RegWriteEn, 0);
        next_cycle();
        @(negedge Clk);
        check("hold_release_alu", {ImmGnt, LdGnt, AluGnt}, 3'b001);
        next_cycle();
        AluReq = 1'b0; ImmReq = 1'b0;
        @(negedge Clk);
        check("hold_alu_written", {RegWriteEn, WrAddr, WrData}, {1'b1, 4'd6, 8'h66});
        next_cycle();

        // Hold with only Alu pending, then r7=11 lands for the bypass check.
        Hold = 1'b1; AluReq = 1'b1; AluAddr = 4'd7; AluData = 8'h11;
        repeat (4) begin
            @(negedge Clk);
            check("hold_alu_blocked", AluGnt, 0);
            next_cycle();
        end
        Hold = 1'b0;
        @(negedge Clk);
        check("hold_alu_first", AluGnt, 1);
        next_cycle();
        AluReq = 1'b0; RdAddr = 4'd7;
        #1;
`ifdef RF_BYPASS_EN
        check("bypass_hit", {BypassHit, BypassData}, {1'b1, 8'h11});
`else
        check("bypass_off", {BypassHit, BypassData}, 0);
`endif
        RdAddr = 4'd6;
        #1;
        check("bypass_miss", {BypassHit, BypassData}, 0);

        // Asynchronous reset mid-write clears outputs without a clock edge.
        check("midwrite_we", RegWriteEn, 1);
        Reset_n = 1'b0;
        #1;
        check("async_rst_out", {RegWriteEn, WrAddr, WrData}, 0);
        next_cycle();
        Reset_n = 1'b1;
        next_cycle();

        // Randomized traffic; the model process does all checking here.
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clk);
            g_imm = ImmGnt; g_ld = LdGnt; g_alu = AluGnt;
            next_cycle();
            Reset_n = 1'b1;
            step_req(ImmReq, g_imm, ImmReq, fresh);
            if (fresh) ImmData = W'($urandom);
            step_req(LdReq, g_ld, LdReq, fresh);
            if (fresh) begin LdAddr = D'($urandom); LdData = W'($urandom); end
            step_req(AluReq, g_alu, AluReq, fresh);
            if (fresh) begin AluAddr = D'($urandom); AluData = W'($urandom); end
            Hold   = ($urandom_range(0, 9) == 0);
            RdAddr = D'($urandom);
            if ($urandom_range(0, 499) == 0) Reset_n = 1'b0;
        end
        Reset_n = 1'b1; Hold = 1'b0;
        ImmReq = 1'b0; LdReq = 1'b0; AluReq = 1'b0;
        repeat (2) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
